ctrl_sequencer: RTL

- Multi-cycle control sequencer that sits directly upstream of the 10-bit ALU stage.
- Latches a 10-bit instruction and steps through T1..T3 timing states.
- Drives the ALU controls (FN, Ain, Gin, Gout) plus register-file and bus-source enables.
- Pulses Done when the result has been written back to Rx.

---
 rtl/ctrl_sequencer_if.sv | 43 ++++
 rtl/ctrl_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the instruction sequencer and the ALU/register-file datapath.
// Err exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface ctrl_sequencer_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned NREG   = 4
);
    logic [DATA_W-1:0] INSTR;
    logic              Exec;
    logic [3:0]        FN;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic [NREG-1:0]   Rin;
    logic [NREG-1:0]   Rout;
    logic              IMMout;
    logic [DATA_W-1:0] IMM;
    logic              EXTout;
    logic              Busy;
    logic              Done;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic              Err;
`endif

`ifdef CTRL_ILLEGAL_TRAP_EN
    modport master (
        input  INSTR, Exec,
        output FN, Ain, Gin, Gout, Rin, Rout, IMMout, IMM, EXTout, Busy, Done, Err
    );
    modport slave (
        output INSTR, Exec,
        input  FN, Ain, Gin, Gout, Rin, Rout, IMMout, IMM, EXTout, Busy, Done, Err
    );
`else
    modport master (
        input  INSTR, Exec,
        output FN, Ain, Gin, Gout, Rin, Rout, IMMout, IMM, EXTout, Busy, Done
    );
    modport slave (
        output INSTR, Exec,
        input  FN, Ain, Gin, Gout, Rin, Rout, IMMout, IMM, EXTout, Busy, Done
    );
`endif
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle T1..T3 control sequencer driving the 10-bit ALU stage.
// CTRL_ILLEGAL_TRAP_EN: reserved opcodes raise sticky Err instead of executing as NOP.
module ctrl_sequencer #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned NREG   = 4
) (
    input  logic             CLKb,
    input  logic             RSTb,
    ctrl_sequencer_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] T1   = 2'd1;
    localparam logic [1:0] T2   = 2'd2;
    localparam logic [1:0] T3   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;

    logic [3:0] opcode;
    logic [1:0] rx, ry;
    logic       is_load, is_unary, is_binary, is_shift, is_imm, is_rsvd;
    logic [1:0] last_step;
    logic       final_step, trap, exec_blocked, accept;

    assign opcode = ir_q[9:6];
    assign rx     = ir_q[5:4];
    assign ry     = ir_q[3:2];

    always_comb begin
        is_load   = 1'b0;
        is_unary  = 1'b0;
        is_binary = 1'b0;
        is_shift  = 1'b0;
        is_imm    = 1'b0;
        is_rsvd   = 1'b0;
        case (opcode)
            4'b0000:                                     is_load   = 1'b1;
            4'b0001, 4'b0100, 4'b0101:                   is_unary  = 1'b1;
            4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: is_binary = 1'b1;
            4'b1001, 4'b1010, 4'b1011:                   is_shift  = 1'b1;
            4'b1100, 4'b1101:                            is_imm    = 1'b1;
            default:                                     is_rsvd   = 1'b1;
        endcase
    end

    always_comb begin
        if (is_rsvd)                  last_step = T1;
        else if (is_load || is_shift) last_step = T2;
        else                          last_step = T3;
    end

    assign final_step = (state_q != IDLE) && (state_q == last_step);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic err_q;

    assign trap         = is_rsvd && (state_q == T1);
    assign exec_blocked = err_q;

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) err_q <= 1'b0;
        else       err_q <= err_q | trap;
    end

    assign bus.Err = err_q;
`else
    assign trap         = 1'b0;
    assign exec_blocked = 1'b0;
`endif

    // A trapping step is final but must drop to IDLE rather than chain a new instruction.
    assign accept = bus.Exec && !exec_blocked && !trap && ((state_q == IDLE) || final_step);

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        if (accept) begin
            state_d = T1;
            ir_d    = bus.INSTR;
        end else if (final_step) begin
            state_d = IDLE;
        end else if (state_q != IDLE) begin
            state_d = state_q + 2'd1;
        end
    end

    always_ff @(posedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= IDLE;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    logic       rout_en, rin_en;
    logic [1:0] rout_sel;

    always_comb begin
        bus.FN     = 4'b0000;
        bus.Ain    = 1'b0;
        bus.Gin    = 1'b0;
        bus.Gout   = 1'b0;
        bus.IMMout = 1'b0;
        bus.EXTout = 1'b0;
        bus.Busy   = 1'b0;
        rout_en    = 1'b0;
        rout_sel   = 2'd0;
        rin_en     = 1'b0;
        if (state_q != IDLE) begin
            bus.FN   = opcode;
            bus.Busy = 1'b1;
        end
        case (state_q)
            T1: begin
                if (is_load) begin
                    bus.EXTout = 1'b1;
                    bus.Gin    = 1'b1;
                end else if (is_unary || is_binary) begin
                    rout_en  = 1'b1;
                    rout_sel = ry;
                    bus.Ain  = 1'b1;
                end else if (is_shift) begin
                    rout_en  = 1'b1;
                    rout_sel = rx;
                    bus.Gin  = 1'b1;
                end else if (is_imm) begin
                    bus.IMMout = 1'b1;
                    bus.Ain    = 1'b1;
                end
            end
            T2: begin
                if (is_load || is_shift) begin
                    bus.Gout = 1'b1;
                    rin_en   = 1'b1;
                end else if (is_unary) begin
                    bus.Gin = 1'b1;
                end else if (is_binary || is_imm) begin
                    rout_en  = 1'b1;
                    rout_sel = rx;
                    bus.Gin  = 1'b1;
                end
            end
            T3: begin
                bus.Gout = 1'b1;
                rin_en   = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.Rout = rout_en ? (NREG'(1) << rout_sel) : '0;
    assign bus.Rin  = rin_en ? (NREG'(1) << rx) : '0;
    assign bus.Done = final_step && !trap;
    assign bus.IMM  = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
endmodule
